// File: rtl/arith_pipe.sv
// Two-stage valid/ready add/sub/xor/and-not unit with carry/zero chaining
// so operands wider than WIDTH can be processed as consecutive beats.
module arith_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       op,
    input  logic             sign,
    input  logic             cin,
    input  logic             chain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ofl,
    output logic             zero
);

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_XOR  = 2'b10,
        OP_ANDN = 2'b11
    } op_e;

    localparam int MSB = WIDTH - 1;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    op_e              r_op;
    logic             r_sign;
    logic             r_cin;
    logic             r_chain;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out;
    logic             r_cout;
    logic             r_ofl;
    logic             r_zero;
    logic             r_carry_q;
    logic             r_zero_q;

    logic             w_adv;
    logic             w_load1;
    logic             w_load2;
    logic             w_c;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_cout;
    logic             w_ofl;
    logic             w_zero;

    assign w_adv    = ~r_out_valid | out_ready;
    assign in_ready = ~r_s1_valid | w_adv;
    assign w_load1  = in_valid & in_ready;
    assign w_load2  = r_s1_valid & w_adv;

    always_comb begin
        w_c     = 1'b0;
        w_b_eff = r_b;
        w_sum   = '0;
        w_res   = '0;
        w_cout  = 1'b0;
        w_ofl   = 1'b0;
        w_zero  = 1'b0;

        // Chained beats take carry from the previous stage-2 result; sub forces
        // the +1 of two's complement when not chained.
        if (r_chain)
            w_c = r_carry_q;
        else if (r_op == OP_SUB)
            w_c = 1'b1;
        else
            w_c = r_cin;

        if (r_op == OP_SUB)
            w_b_eff = ~r_b;
        w_sum = {1'b0, r_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_c};

        case (r_op)
            OP_ADD: begin
                w_res  = w_sum[WIDTH-1:0];
                w_cout = w_sum[WIDTH];
                if (r_sign)
                    w_ofl = (r_a[MSB] == r_b[MSB]) & (w_res[MSB] != r_a[MSB]);
                else
                    w_ofl = w_cout;
            end
            OP_SUB: begin
                w_res  = w_sum[WIDTH-1:0];
                w_cout = w_sum[WIDTH];
                if (r_sign)
                    w_ofl = (r_a[MSB] != r_b[MSB]) & (w_res[MSB] != r_a[MSB]);
                else
                    w_ofl = ~w_cout;
            end
            OP_XOR:  w_res = r_a ^ r_b;
            OP_ANDN: w_res = r_a & ~r_b;
            default: w_res = '0;
        endcase

        w_zero = (w_res == '0) & (r_chain ? r_zero_q : 1'b1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= OP_ADD;
            r_sign      <= 1'b0;
            r_cin       <= 1'b0;
            r_chain     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_cout      <= 1'b0;
            r_ofl       <= 1'b0;
            r_zero      <= 1'b0;
            r_carry_q   <= 1'b0;
            r_zero_q    <= 1'b1;
        end else begin
            if (w_load1) begin
                r_s1_valid <= 1'b1;
                r_a        <= A;
                r_b        <= B;
                r_op       <= op_e'(op);
                r_sign     <= sign;
                r_cin      <= cin;
                r_chain    <= chain;
            end else if (w_adv) begin
                r_s1_valid <= 1'b0;
            end

            if (w_load2) begin
                r_out_valid <= 1'b1;
                r_out       <= w_res;
                r_cout      <= w_cout;
                r_ofl       <= w_ofl;
                r_zero      <= w_zero;
                r_carry_q   <= w_cout;
                r_zero_q    <= w_zero;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign cout      = r_cout;
    assign ofl       = r_ofl;
    assign zero      = r_zero;

endmodule
